// File: rtl/gpr_writeback.sv
// ---------------------------------------------------------------------------
// gpr_writeback
//   Writer-side front end for the GPR write port. Results arrive from the ALU
//   and the LSU over valid/ready, are queued in acceptance order in a small
//   circular FIFO, and leave as at most one GPR write per cycle. Entries that
//   are still queued are forwarded to the decode-stage operand readers, so a
//   consumer sees a value before it reaches the register file.
//
// Parameters
//   DATA_WIDTH  register data width
//   RF_SIZE     register index width (2**RF_SIZE registers)
//   DEPTH       write queue entries (power of 2, >= 2)
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   alu_valid_i/alu_ready_o    ALU result handshake, alu_rd_i/alu_data_i payload
//   lsu_valid_i/lsu_ready_o    LSU result handshake, lsu_rd_i/lsu_data_i payload
//   wb_stall_i                 GPR write port busy this cycle
//   wb_we_o/wb_rd_o/wb_data_o  GPR write (head of queue)
//   byp_rs1_i/byp_rs2_i        operand indices to look up in the queue
//   byp_rsN_hit_o/_data_o      youngest queued value for that index
//   count_o                    number of queued entries
// ---------------------------------------------------------------------------
module gpr_writeback #(
  parameter int DATA_WIDTH = 64,
  parameter int RF_SIZE    = 5,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_valid_i,
  output logic                       alu_ready_o,
  input  logic [RF_SIZE-1:0]         alu_rd_i,
  input  logic [DATA_WIDTH-1:0]      alu_data_i,
  input  logic                       lsu_valid_i,
  output logic                       lsu_ready_o,
  input  logic [RF_SIZE-1:0]         lsu_rd_i,
  input  logic [DATA_WIDTH-1:0]      lsu_data_i,
  input  logic                       wb_stall_i,
  output logic                       wb_we_o,
  output logic [RF_SIZE-1:0]         wb_rd_o,
  output logic [DATA_WIDTH-1:0]      wb_data_o,
  input  logic [RF_SIZE-1:0]         byp_rs1_i,
  input  logic [RF_SIZE-1:0]         byp_rs2_i,
  output logic                       byp_rs1_hit_o,
  output logic [DATA_WIDTH-1:0]      byp_rs1_data_o,
  output logic                       byp_rs2_hit_o,
  output logic [DATA_WIDTH-1:0]      byp_rs2_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Queue storage: data only, never reset (validity comes from count).
  logic [RF_SIZE-1:0]    q_rd   [DEPTH];
  logic [DATA_WIDTH-1:0] q_data [DEPTH];

  // Queue control state.
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic                  full;
  logic                  empty;
  logic                  lsu_fire;
  logic                  alu_fire;
  logic [RF_SIZE-1:0]    push_rd;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH:0]   byp1;
  logic [DATA_WIDTH:0]   byp2;

  // Scan every valid entry from oldest (head) to youngest so that the last
  // match wins; returns {hit, data}. Index 0 is hardwired and never forwards.
  function automatic logic [DATA_WIDTH:0] byp_lookup(input logic [RF_SIZE-1:0] rs);
    logic [DATA_WIDTH:0] res;
    logic [PTR_W-1:0]    idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (rs != '0) && (q_rd[idx] == rs)) begin
        res = {1'b1, q_data[idx]};
      end
    end
    return res;
  endfunction

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // LSU has fixed priority; neither ready depends on its own valid.
  // A full queue refuses input even when the head pops this cycle.
  assign lsu_ready_o = !full;
  assign alu_ready_o = !full && !lsu_valid_i;

  assign lsu_fire = lsu_valid_i && lsu_ready_o;
  assign alu_fire = alu_valid_i && alu_ready_o;

  assign push_rd   = lsu_fire ? lsu_rd_i   : alu_rd_i;
  assign push_data = lsu_fire ? lsu_data_i : alu_data_i;

  // Writes to x0 complete the handshake but are dropped here.
  assign push = (lsu_fire || alu_fire) && (push_rd != '0);
  assign pop  = !empty && !wb_stall_i;

  assign wb_we_o   = pop;
  assign wb_rd_o   = empty ? '0 : q_rd[head];
  assign wb_data_o = empty ? '0 : q_data[head];

  assign count_o = count;

  always_comb begin
    byp1 = byp_lookup(byp_rs1_i);
    byp2 = byp_lookup(byp_rs2_i);
  end

  assign byp_rs1_hit_o  = byp1[DATA_WIDTH];
  assign byp_rs1_data_o = byp1[DATA_WIDTH-1:0];
  assign byp_rs2_hit_o  = byp2[DATA_WIDTH];
  assign byp_rs2_data_o = byp2[DATA_WIDTH-1:0];

  // Control state: pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[tail]   <= push_rd;
      q_data[tail] <= push_data;
    end
  end

endmodule

// File: tb/tb_gpr_writeback.sv
// ---------------------------------------------------------------------------
// tb_gpr_writeback
//   Directed bench for gpr_writeback. Accepted results are pushed to a
//   scoreboard queue; every GPR write is popped from it and compared.
// ---------------------------------------------------------------------------
module tb_gpr_writeback;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic        wb_stall;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [4:0]  byp_rs1;
  logic [4:0]  byp_rs2;
  logic        byp_rs1_hit;
  logic [63:0] byp_rs1_data;
  logic        byp_rs2_hit;
  logic [63:0] byp_rs2_data;
  logic [2:0]  count;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  ent_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  gpr_writeback #(.DATA_WIDTH(64), .RF_SIZE(5), .DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_valid_i    (alu_valid),
    .alu_ready_o    (alu_ready),
    .alu_rd_i       (alu_rd),
    .alu_data_i     (alu_data),
    .lsu_valid_i    (lsu_valid),
    .lsu_ready_o    (lsu_ready),
    .lsu_rd_i       (lsu_rd),
    .lsu_data_i     (lsu_data),
    .wb_stall_i     (wb_stall),
    .wb_we_o        (wb_we),
    .wb_rd_o        (wb_rd),
    .wb_data_o      (wb_data),
    .byp_rs1_i      (byp_rs1),
    .byp_rs2_i      (byp_rs2),
    .byp_rs1_hit_o  (byp_rs1_hit),
    .byp_rs1_data_o (byp_rs1_data),
    .byp_rs2_hit_o  (byp_rs2_hit),
    .byp_rs2_data_o (byp_rs2_data),
    .count_o        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every GPR write must match the oldest outstanding accepted result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wb_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected_write", {59'd0, wb_rd}, 64'd0);
      end else begin
        ent_t e;
        e = sb.pop_front();
        chk("wb_rd_order", {59'd0, wb_rd}, {59'd0, e.rd});
        chk("wb_data_order", wb_data, e.data);
      end
    end
  end

  // Hold an ALU result until accepted (bounded); record it if it targets rd!=0.
  task automatic send_alu(input logic [4:0] rd, input logic [63:0] data, input string tag);
    logic acc;
    acc = 1'b0;
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = data;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      acc = alu_ready;
      @(posedge clk);
      if (acc) break;
    end
    if (acc && rd != 5'd0) sb.push_back('{rd: rd, data: data});
    #1;
    alu_valid = 1'b0;
    if (!acc) chk({tag, "_accept_timeout"}, {63'd0, acc}, 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic acc;
    rst_n = 1'b0; wb_stall = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'hA1;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 64'hB2;
    byp_rs1 = 5'd0; byp_rs2 = 5'd0;

    // 1: reset with valids high
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", {63'd0, wb_we}, 64'd0);
    chk("rst_count", {61'd0, count}, 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    rst_n = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;
    @(negedge clk);
    chk("rel_lsu_ready", {63'd0, lsu_ready}, 64'd1);
    chk("rel_alu_ready", {63'd0, alu_ready}, 64'd1);
    chk("rel_we", {63'd0, wb_we}, 64'd0);
    @(posedge clk); #1;

    // 2: single ALU write, one-cycle latency
    send_alu(5'd5, 64'hDEAD, "t2");
    chk("t2_we", {63'd0, wb_we}, 64'd1);
    chk("t2_rd", {59'd0, wb_rd}, 64'd5);
    chk("t2_data", wb_data, 64'hDEAD);
    chk("t2_count_n1", {61'd0, count}, 64'd1);
    idle(1);
    chk("t2_count_n2", {61'd0, count}, 64'd0);

    // 3: LSU beats ALU, ALU follows next cycle
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 64'h11;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'h22;
    @(negedge clk);
    chk("t3_alu_ready_lo", {63'd0, alu_ready}, 64'd0);
    chk("t3_lsu_ready", {63'd0, lsu_ready}, 64'd1);
    @(posedge clk);
    sb.push_back('{rd: 5'd3, data: 64'h11});
    #1; lsu_valid = 1'b0;
    @(negedge clk);
    chk("t3_alu_ready_hi", {63'd0, alu_ready}, 64'd1);
    chk("t3_first_rd", {59'd0, wb_rd}, 64'd3);
    @(posedge clk);
    sb.push_back('{rd: 5'd4, data: 64'h22});
    #1; alu_valid = 1'b0;
    @(negedge clk);
    chk("t3_second_we", {63'd0, wb_we}, 64'd1);
    chk("t3_second_rd", {59'd0, wb_rd}, 64'd4);
    idle(2);
    chk("t3_drained", {61'd0, count}, 64'd0);

    // 4: fill under stall, no pass-through when full
    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) send_alu(5'(8 + i), 64'(100 + i), "t4_fill");
    chk("t4_count_full", {61'd0, count}, 64'd4);
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 64'h12C;
    repeat (2) begin
      @(negedge clk);
      chk("t4_alu_ready_full", {63'd0, alu_ready}, 64'd0);
      chk("t4_lsu_ready_full", {63'd0, lsu_ready}, 64'd0);
      chk("t4_stalled_we", {63'd0, wb_we}, 64'd0);
      @(posedge clk); #1;
    end
    wb_stall = 1'b0;
    @(negedge clk);
    chk("t4_no_passthru", {63'd0, alu_ready}, 64'd0);
    chk("t4_pop_rd", {59'd0, wb_rd}, 64'd8);
    @(posedge clk);
    acc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      acc = alu_ready;
      @(posedge clk);
      if (acc) break;
    end
    if (acc) sb.push_back('{rd: 5'd12, data: 64'h12C});
    chk("t4_fifth_accepted", {63'd0, acc}, 64'd1);
    #1; alu_valid = 1'b0;
    idle(6);
    chk("t4_drained", {61'd0, count}, 64'd0);

    // 5: bypass, youngest wins, x0 never hits
    wb_stall = 1'b1;
    send_alu(5'd7, 64'd1, "t5a");
    send_alu(5'd7, 64'd2, "t5b");
    byp_rs1 = 5'd7; byp_rs2 = 5'd0;
    #1;
    chk("t5_rs1_hit", {63'd0, byp_rs1_hit}, 64'd1);
    chk("t5_rs1_young", byp_rs1_data, 64'd2);
    chk("t5_rs2_x0_hit", {63'd0, byp_rs2_hit}, 64'd0);
    chk("t5_rs2_x0_data", byp_rs2_data, 64'd0);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99; byp_rs2 = 5'd9;
    @(negedge clk);
    chk("t5_not_yet_hit", {63'd0, byp_rs2_hit}, 64'd0);
    @(posedge clk);
    sb.push_back('{rd: 5'd9, data: 64'h99});
    #1; alu_valid = 1'b0;
    chk("t5_new_hit", {63'd0, byp_rs2_hit}, 64'd1);
    chk("t5_new_data", byp_rs2_data, 64'h99);
    wb_stall = 1'b0;
    @(negedge clk);
    chk("t5_pop1_hit_data", byp_rs1_data, 64'd2);
    @(posedge clk);
    @(negedge clk);
    chk("t5_popping_hit", {63'd0, byp_rs1_hit}, 64'd1);
    chk("t5_popping_data", byp_rs1_data, 64'd2);
    @(posedge clk);
    @(negedge clk);
    chk("t5_gone_hit", {63'd0, byp_rs1_hit}, 64'd0);
    chk("t5_gone_data", byp_rs1_data, 64'd0);
    idle(2);
    chk("t5_drained", {61'd0, count}, 64'd0);

    // 6: x0 dropped; reset discards queued writes
    send_alu(5'd0, 64'h55, "t6_x0");
    chk("t6_x0_count", {61'd0, count}, 64'd0);
    @(negedge clk);
    chk("t6_x0_no_we", {63'd0, wb_we}, 64'd0);
    @(posedge clk); #1;
    wb_stall = 1'b1;
    send_alu(5'd20, 64'h200, "t6q");
    send_alu(5'd21, 64'h201, "t6q");
    send_alu(5'd22, 64'h202, "t6q");
    chk("t6_count3", {61'd0, count}, 64'd3);
    rst_n = 1'b0;
    @(posedge clk);
    sb.delete();
    #1;
    chk("t6_rst_count", {61'd0, count}, 64'd0);
    rst_n = 1'b1; wb_stall = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t6_no_write_after_rst", {63'd0, wb_we}, 64'd0);
      @(posedge clk);
    end
    #1;
    chk("end_sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
